pk_vault_ctrl: RTL and testbench

//  Parametrised top-level sequencer for the Pass-Keeper vault.
//  - At boot, replays flash entries 0..max_add into the CAM.
//  - Per request: runs a CAM lookup.
//    - Hit: decrypts the stored password and presents it.
//    - Miss: encrypts the new password, then appends it to flash and CAM at the next free address.
//  - Adds over the fixed 4-bit controller: table-full detection, enc/dec timeout watchdog,

---
 rtl/pk_pkg.sv | 25 ++
 rtl/pk_watchdog.sv | 34 +++
 rtl/pk_vault_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_pk_vault_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pk_pkg.sv
// Shared types and constants for the Pass-Keeper vault controller.
//   state_e : sequencer states (boot replay, request handling, result output)
//   PK_ERR_*: values reported on err_code
package pk_pkg;

    typedef enum logic [3:0] {
        StBootRd,
        StBootWr,
        StIdle,
        StLookup,
        StCamWait,
        StDec,
        StDecWait,
        StEnc,
        StEncWait,
        StStore,
        StOut
    } state_e;

    localparam logic [1:0] PK_ERR_NONE    = 2'b00;
    localparam logic [1:0] PK_ERR_FULL    = 2'b01;
    localparam logic [1:0] PK_ERR_ENC_TMO = 2'b10;
    localparam logic [1:0] PK_ERR_DEC_TMO = 2'b11;

endpackage

// File: rtl/pk_watchdog.sv
// Encrypt/decrypt watchdog for the vault controller.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart the count at zero
//   en       : count this cycle (saturates at all-ones, never wraps)
//   expire   : count has reached TMO_CYC-1
module pk_watchdog #(
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_CYC = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + TMO_W'(1);
        end
    end

    // Not gated by en: the sequencer only looks at it in the wait states.
    assign expire = (cnt_q == LAST);

endmodule

// File: rtl/pk_vault_ctrl.sv
// Top-level sequencer for the Pass-Keeper vault.
// Replays flash entries 0..max_add into the CAM at boot, then serves requests:
// CAM hit -> decrypt stored password; miss -> encrypt and append to flash + CAM.
//   clk, rst                     : clock, asynchronous active-high reset
//   go, max_add                  : request strobe, last valid flash address at boot
//   cam_valid, match, match_addr : CAM lookup response
//   enc_done, dec_done           : crypto completion pulses
//   cam_start .. start_dec       : datapath strobes (one cycle each)
//   address_out, new_old_sel     : table address and password source select
//   out_reg, done, err, err_code : result load, completion, error pulse and sticky code
//   boot_done, busy              : status levels
// Every output is registered: actions of a state appear in the cycle after that state.
module pk_vault_ctrl
    import pk_pkg::*;
#(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_CYC = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [ADDR_W-1:0] max_add,
    input  logic              cam_valid,
    input  logic              match,
    input  logic [ADDR_W-1:0] match_addr,
    input  logic              enc_done,
    input  logic              dec_done,
    output logic              cam_start,
    output logic              cam_write_en,
    output logic              flash_rd_en,
    output logic              flash_wr_en,
    output logic              start_enc,
    output logic              start_dec,
    output logic [ADDR_W-1:0] address_out,
    output logic              new_old_sel,
    output logic              out_reg,
    output logic              done,
    output logic              boot_done,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W:0] TABLE_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] max_q, max_d;
    logic [ADDR_W:0]   used_q, used_d;

    logic cam_start_d, cam_write_en_d, flash_rd_en_d, flash_wr_en_d;
    logic start_enc_d, start_dec_d, new_old_sel_d, out_reg_d, done_d;
    logic boot_done_d, err_d;
    logic [1:0] err_code_d;
    logic wd_clr, wd_en, wd_expire;

    pk_watchdog #(
        .TMO_W  (TMO_W),
        .TMO_CYC(TMO_CYC)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (wd_clr),
        .en    (wd_en),
        .expire(wd_expire)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        max_d          = max_q;
        used_d         = used_q;
        cam_start_d    = 1'b0;
        cam_write_en_d = 1'b0;
        flash_rd_en_d  = 1'b0;
        flash_wr_en_d  = 1'b0;
        start_enc_d    = 1'b0;
        start_dec_d    = 1'b0;
        out_reg_d      = 1'b0;
        done_d         = 1'b0;
        err_d          = 1'b0;
        new_old_sel_d  = new_old_sel;
        boot_done_d    = boot_done;
        err_code_d     = err_code;
        wd_clr         = 1'b0;
        wd_en          = 1'b0;

        unique case (state_q)
            StBootRd: begin
                flash_rd_en_d = 1'b1;
                max_d         = max_add;
                state_d       = StBootWr;
            end
            StBootWr: begin
                cam_write_en_d = 1'b1;
                if (addr_q == max_q) begin
                    used_d      = {1'b0, max_q} + (ADDR_W+1)'(1);
                    boot_done_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StBootRd;
                end
            end
            StIdle: begin
                if (go) state_d = StLookup;
            end
            StLookup: begin
                cam_start_d = 1'b1;
                state_d     = StCamWait;
            end
            StCamWait: begin
                wd_en = 1'b1;
                if (cam_valid) begin
                    if (match) begin
                        addr_d        = match_addr;
                        new_old_sel_d = 1'b0;
                        state_d       = StDec;
                    end else if (used_q == TABLE_FULL) begin
                        // Full check before any address is derived from used_q.
                        err_d      = 1'b1;
                        err_code_d = PK_ERR_FULL;
                        state_d    = StIdle;
                    end else begin
                        addr_d        = used_q[ADDR_W-1:0];
                        new_old_sel_d = 1'b1;
                        state_d       = StEnc;
                    end
                end
            end
            StDec: begin
                start_dec_d = 1'b1;
                wd_clr      = 1'b1;
                state_d     = StDecWait;
            end
            StDecWait: begin
                wd_en = 1'b1;
                // Completion takes priority over a same-cycle expiry.
                if (dec_done) begin
                    state_d = StOut;
                end else if (wd_expire) begin
                    err_d      = 1'b1;
                    err_code_d = PK_ERR_DEC_TMO;
                    state_d    = StIdle;
                end
            end
            StEnc: begin
                start_enc_d = 1'b1;
                wd_clr      = 1'b1;
                state_d     = StEncWait;
            end
            StEncWait: begin
                wd_en = 1'b1;
                if (enc_done) begin
                    state_d = StStore;
                end else if (wd_expire) begin
                    err_d      = 1'b1;
                    err_code_d = PK_ERR_ENC_TMO;
                    state_d    = StIdle;
                end
            end
            StStore: begin
                flash_wr_en_d  = 1'b1;
                cam_write_en_d = 1'b1;
                used_d         = used_q + (ADDR_W+1)'(1);
                state_d        = StOut;
            end
            StOut: begin
                out_reg_d = 1'b1;
                done_d    = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StBootRd;
            addr_q       <= '0;
            max_q        <= '0;
            used_q       <= '0;
            cam_start    <= 1'b0;
            cam_write_en <= 1'b0;
            flash_rd_en  <= 1'b0;
            flash_wr_en  <= 1'b0;
            start_enc    <= 1'b0;
            start_dec    <= 1'b0;
            address_out  <= '0;
            new_old_sel  <= 1'b0;
            out_reg      <= 1'b0;
            done         <= 1'b0;
            boot_done    <= 1'b0;
            busy         <= 1'b1;
            err          <= 1'b0;
            err_code     <= PK_ERR_NONE;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            max_q        <= max_d;
            used_q       <= used_d;
            cam_start    <= cam_start_d;
            cam_write_en <= cam_write_en_d;
            flash_rd_en  <= flash_rd_en_d;
            flash_wr_en  <= flash_wr_en_d;
            start_enc    <= start_enc_d;
            start_dec    <= start_dec_d;
            // Lags addr_q so the address lines up with the strobes of the same state.
            address_out  <= addr_q;
            new_old_sel  <= new_old_sel_d;
            out_reg      <= out_reg_d;
            done         <= done_d;
            boot_done    <= boot_done_d;
            // Tracks the state being entered, so busy is low exactly while idle.
            busy         <= (state_d != StIdle);
            err          <= err_d;
            err_code     <= err_code_d;
        end
    end

endmodule

// File: tb/tb_pk_vault_ctrl.sv
// Self-checking bench for pk_vault_ctrl: a transaction-level model lays out the
// expected output vector for every cycle; one process compares it on each falling edge.
module tb_pk_vault_ctrl;

    localparam int AW    = 3;
    localparam int TW    = 4;
    localparam int TMO   = 5;
    localparam int DEPTH = 8;

    logic clk, rst, go, cam_valid, match, enc_done, dec_done;
    logic [AW-1:0] max_add, match_addr, address_out;
    logic cam_start, cam_write_en, flash_rd_en, flash_wr_en, start_enc, start_dec;
    logic new_old_sel, out_reg, done, boot_done, busy, err;
    logic [1:0] err_code;

    pk_vault_ctrl #(
        .ADDR_W (AW),
        .TMO_W  (TW),
        .TMO_CYC(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .max_add     (max_add),
        .cam_valid   (cam_valid),
        .match       (match),
        .match_addr  (match_addr),
        .enc_done    (enc_done),
        .dec_done    (dec_done),
        .cam_start   (cam_start),
        .cam_write_en(cam_write_en),
        .flash_rd_en (flash_rd_en),
        .flash_wr_en (flash_wr_en),
        .start_enc   (start_enc),
        .start_dec   (start_dec),
        .address_out (address_out),
        .new_old_sel (new_old_sel),
        .out_reg     (out_reg),
        .done        (done),
        .boot_done   (boot_done),
        .busy        (busy),
        .err         (err),
        .err_code    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          cam_start, cam_write_en, flash_rd_en, flash_wr_en, start_enc, start_dec;
        logic [AW-1:0] address_out;
        logic          new_old_sel, out_reg, done, boot_done, busy, err;
        logic [1:0]    err_code;
    } out_t;

    out_t exp_o;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;

    // Model state: values the held outputs must show, and table occupancy.
    logic [AW-1:0] m_addr  = '0;
    logic          m_nos   = 1'b0;
    logic [1:0]    m_ecode = 2'b00;
    logic          m_boot  = 1'b0;
    int            m_used  = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cam_start",    cam_start,    exp_o.cam_start);
            chk("cam_write_en", cam_write_en, exp_o.cam_write_en);
            chk("flash_rd_en",  flash_rd_en,  exp_o.flash_rd_en);
            chk("flash_wr_en",  flash_wr_en,  exp_o.flash_wr_en);
            chk("start_enc",    start_enc,    exp_o.start_enc);
            chk("start_dec",    start_dec,    exp_o.start_dec);
            chk("address_out",  address_out,  exp_o.address_out);
            chk("new_old_sel",  new_old_sel,  exp_o.new_old_sel);
            chk("out_reg",      out_reg,      exp_o.out_reg);
            chk("done",         done,         exp_o.done);
            chk("boot_done",    boot_done,    exp_o.boot_done);
            chk("busy",         busy,         exp_o.busy);
            chk("err",          err,          exp_o.err);
            chk("err_code",     err_code,     exp_o.err_code);
        end
    end

    function automatic out_t base(input bit bsy);
        out_t e = '0;
        e.address_out = m_addr;
        e.new_old_sel = m_nos;
        e.boot_done   = m_boot;
        e.busy        = bsy;
        e.err_code    = m_ecode;
        return e;
    endfunction

    // Advance one clock; e is what the outputs must show after that edge.
    task automatic step(input out_t e);
        @(posedge clk);
        #1;
        exp_o = e;
    endtask

    task automatic clear_inputs();
        go = 1'b0; cam_valid = 1'b0; enc_done = 1'b0; dec_done = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        m_addr = '0; m_nos = 1'b0; m_ecode = 2'b00; m_boot = 1'b0; m_used = 0;
        exp_o = base(1'b1);
        #1;
        chk("rst_flash_rd_en", flash_rd_en, 0);
        chk("rst_start_enc",   start_enc,   0);
        chk("rst_boot_done",   boot_done,   0);
        chk("rst_busy",        busy,        1);
        chk("rst_err_code",    err_code,    0);
        chk("rst_address_out", address_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Boot replay of entries 0..m; reports the cycle on which boot_done was first seen.
    task automatic boot(input int m, output int bd_cyc);
        out_t e;
        int   k = 0;
        bd_cyc  = -1;
        max_add = AW'(m);
        for (int i = 0; i <= m; i++) begin
            m_addr = AW'(i);
            e = base(1'b1);
            e.flash_rd_en = 1'b1;
            step(e);
            k++;
            if (boot_done && bd_cyc < 0) bd_cyc = k;
            if (i == m) m_boot = 1'b1;
            e = base(i != m);
            e.cam_write_en = 1'b1;
            step(e);
            k++;
            if (boot_done && bd_cyc < 0) bd_cyc = k;
        end
        m_used  = m + 1;
        max_add = AW'($urandom);
    endtask

    // Crypto wait: done pulse in wait cycle w (w > TMO means never). res: 0 timeout, 1 done, 2 abort.
    task automatic wait_phase(input bit is_dec, input int w, input int abort_at, output int res);
        out_t e;
        res = 0;
        for (int j = 1; j <= TMO; j++) begin
            if (j == abort_at) begin
                res = 2;
                return;
            end
            // Stray go / cam_valid while busy must be ignored.
            go         = 1'($urandom_range(0, 1));
            cam_valid  = 1'($urandom_range(0, 1));
            match      = 1'($urandom_range(0, 1));
            match_addr = AW'($urandom);
            if (j == w) begin
                if (is_dec) dec_done = 1'b1;
                else        enc_done = 1'b1;
                step(base(1'b1));
                clear_inputs();
                res = 1;
                return;
            end
            if (j == TMO) begin
                m_ecode = is_dec ? 2'b11 : 2'b10;
                e = base(1'b0);
                e.err = 1'b1;
                step(e);
                clear_inputs();
                res = 0;
                return;
            end
            step(base(1'b1));
            clear_inputs();
        end
    endtask

    // mode: 0 random, 1 hit at index 2, 2 miss. w = 0 picks a random done cycle.
    // lit >= 0 pins address_out at the start_dec / store cycle to that literal.
    task automatic request(input int mode, input int w, input int abort_at, input int lit,
                           output int res);
        out_t e;
        bit   hit;
        int   idx = 0;
        res = 1;
        if (mode == 1)      begin hit = 1'b1; idx = 2; end
        else if (mode == 2) hit = 1'b0;
        else begin
            hit = (m_used > 0) && ($urandom_range(0, 1) == 1);
            if (hit) idx = $urandom_range(0, m_used - 1);
        end
        if (w == 0) w = $urandom_range(1, TMO + 1);

        go = 1'b1;
        step(base(1'b1));
        go = 1'b0;
        e = base(1'b1);
        e.cam_start = 1'b1;
        step(e);
        repeat ($urandom_range(0, 2)) step(base(1'b1));

        cam_valid  = 1'b1;
        match      = hit;
        match_addr = hit ? AW'(idx) : AW'($urandom);
        if (hit) begin
            m_nos = 1'b0;
            step(base(1'b1));
            cam_valid = 1'b0;
            m_addr = AW'(idx);
            e = base(1'b1);
            e.start_dec = 1'b1;
            step(e);
            if (lit >= 0) chk("hit_addr", address_out, lit);
            wait_phase(1'b1, w, abort_at, res);
            if (res == 1) begin
                e = base(1'b0);
                e.out_reg = 1'b1;
                e.done    = 1'b1;
                step(e);
            end
        end else if (m_used == DEPTH) begin
            m_ecode = 2'b01;
            e = base(1'b0);
            e.err = 1'b1;
            step(e);
            cam_valid = 1'b0;
            chk("full_code", err_code, 1);
        end else begin
            m_nos = 1'b1;
            step(base(1'b1));
            cam_valid = 1'b0;
            m_addr = AW'(m_used);
            e = base(1'b1);
            e.start_enc = 1'b1;
            step(e);
            wait_phase(1'b0, w, abort_at, res);
            if (res == 1) begin
                e = base(1'b1);
                e.flash_wr_en  = 1'b1;
                e.cam_write_en = 1'b1;
                step(e);
                if (lit >= 0) chk("store_addr", address_out, lit);
                m_used++;
                e = base(1'b0);
                e.out_reg = 1'b1;
                e.done    = 1'b1;
                step(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            cam_valid  = 1'($urandom_range(0, 1));
            match      = 1'b1;
            match_addr = AW'($urandom);
            step(base(1'b0));
            cam_valid = 1'b0;
        end
    endtask

    initial begin
        int bd, res;
        rst = 1'b0; go = 1'b0; cam_valid = 1'b0; match = 1'b0; match_addr = '0;
        enc_done = 1'b0; dec_done = 1'b0; max_add = '0;
        exp_o = base(1'b1);
        #2;
        chk_en = 1'b1;
        apply_reset();

        // Boot of 4 entries: boot_done on the 8th edge.
        boot(3, bd);
        chk("boot_done_cycle", bd, 8);
        idle(2);
        request(1, 2, 0, 2, res);          // hit at 2
        idle(1);
        request(2, 3, 0, 4, res);          // miss -> append at 4
        request(1, TMO + 1, 0, -1, res);   // decrypt timeout
        chk("dec_tmo_code", err_code, 3);
        request(2, TMO, 0, 5, res);        // enc_done on the expiry cycle: stored at 5
        chk("enc_done_wins", res, 1);
        request(2, TMO + 1, 3, -1, res);   // reset while waiting for encryption
        chk("abort_taken", res, 2);
        apply_reset();

        // Full table: next miss reports table full.
        boot(DEPTH - 1, bd);
        chk("boot_full_cycle", bd, 2 * DEPTH);
        idle(1);
        request(2, 0, 0, -1, res);
        idle(2);

        repeat (5) begin
            apply_reset();
            boot($urandom_range(0, DEPTH - 1), bd);
            repeat (20) begin
                request(0, 0, 0, -1, res);
                idle($urandom_range(0, 3));
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
